// File: rtl/imem_loader.sv
// imem_loader: 64x32 instruction store, byte-stream loader, core reset gate.
// Optional IMEM_ZERO_FILL_EN: zero words len..DEPTH-1 before releasing core.
module imem_loader #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [AW-1:0] pc,
  output logic [31:0]   idata,
  output logic          core_nrst,
  output logic          busy,
  output logic          err
);

`ifdef IMEM_ZERO_FILL_EN
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_FILL, S_RUN
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_RUN
  } state_t;
`endif

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [LW-1:0] len_q;
  logic [AW-1:0] word_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_q;
  logic          err_q;
  logic          core_nrst_q;
  logic [31:0]   idata_q;

  logic          legal;
  logic          accept;
  logic          last_byte;
  logic          last_word;
  logic          start_ok;
  logic          start_bad;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic          fill_step;

  assign legal     = (len != '0) && (len <= LW'(DEPTH));
  assign accept    = rx_valid & rx_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = ({1'b0, word_cnt} == (len_q - LW'(1)));

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = {asm_q, rx_data};
    fill_step = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (legal) begin
            state_d  = S_LOAD;
            start_ok = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (last_byte) begin
          mem_we = 1'b1;
          if (last_word) begin
`ifdef IMEM_ZERO_FILL_EN
            if (len_q < LW'(DEPTH)) state_d = S_FILL;
            else                    state_d = S_RUN;
`else
            state_d = S_RUN;
`endif
          end
        end
      end
`ifdef IMEM_ZERO_FILL_EN
      S_FILL: begin
        mem_we    = 1'b1;
        mem_wd    = '0;
        fill_step = 1'b1;
        if (word_cnt == AW'(DEPTH - 1)) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      asm_q       <= '0;
      err_q       <= 1'b0;
      core_nrst_q <= 1'b0;
      idata_q     <= '0;
    end else begin
      state_q     <= state_d;
      core_nrst_q <= (state_d == S_RUN);
      idata_q     <= (state_q == S_RUN) ? mem[pc] : '0;
      if (start_ok) begin
        len_q    <= len;
        word_cnt <= '0;
        byte_cnt <= '0;
        err_q    <= 1'b0;
      end else begin
        if (start_bad) err_q <= 1'b1;
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) word_cnt <= word_cnt + AW'(1);
          else                  asm_q    <= {asm_q[15:0], rx_data};
        end
        if (fill_step) word_cnt <= word_cnt + AW'(1);
      end
    end
  end

  // Store has no reset so a reset mid-load keeps already written words.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_cnt] <= mem_wd;
  end

  assign rx_ready  = (state_q == S_LOAD);
`ifdef IMEM_ZERO_FILL_EN
  assign busy      = (state_q == S_LOAD) || (state_q == S_FILL);
`else
  assign busy      = (state_q == S_LOAD);
`endif
  assign idata     = idata_q;
  assign core_nrst = core_nrst_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, fetch, reload, errors, reset.
// Fill-dependent expectations follow IMEM_ZERO_FILL_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [6:0]  len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [5:0]  pc;
  logic [31:0] idata;
  logic        core_nrst;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader #(.DEPTH(64)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .len       (len),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .pc        (pc),
    .idata     (idata),
    .core_nrst (core_nrst),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fill_lat(input int l);
`ifdef IMEM_ZERO_FILL_EN
    return 64 - l;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    chk("rx_ready", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_core(input string tag, input int exp);
    int k;
    k = 0;
    while (!core_nrst && k < 300) begin
      tick();
      k++;
    end
    chk(tag, k, exp);
  endtask

  task automatic fetch(input string tag, input logic [5:0] a,
                       input logic [31:0] exp);
    pc = a;
    tick();
    chk(tag, idata, exp);
  endtask

  initial begin
    nrst     = 1'b0;
    start    = 1'b0;
    len      = '0;
    rx_data  = '0;
    rx_valid = 1'b0;
    pc       = '0;
    #3;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_idata", idata, 32'd0);
    chk("rst_core_nrst", {31'd0, core_nrst}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // illegal length in IDLE
    do_start(7'd0);
    chk("len0_err", {31'd0, err}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("len0_core", {31'd0, core_nrst}, 32'd0);
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("idle_no_accept", {31'd0, busy}, 32'd0);

    // basic load, len=2
    do_start(7'd2);
    chk("load_err_clr", {31'd0, err}, 32'd0);
    chk("load_busy", {31'd0, busy}, 32'd1);
    send_word(32'h20010005, 0);
    send_byte(8'h00, 0);
    send_byte(8'h22, 0);
    send_byte(8'h10, 0);
    chk("pre_last_core", {31'd0, core_nrst}, 32'd0);
    chk("pre_last_idata", idata, 32'd0);
    send_byte(8'h20, 0);
    wait_core("basic_lat", fill_lat(2));
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_rx_ready", {31'd0, rx_ready}, 32'd0);
    fetch("basic_w1", 6'd1, 32'h00221020);
    fetch("basic_w0", 6'd0, 32'h20010005);

    // illegal length in RUN
    do_start(7'd65);
    chk("len65_err", {31'd0, err}, 32'd1);
    chk("len65_core", {31'd0, core_nrst}, 32'd1);
    fetch("len65_fetch", 6'd0, 32'h20010005);

    // reload with back-pressure
    do_start(7'd2);
    chk("bp_core_drop", {31'd0, core_nrst}, 32'd0);
    chk("bp_err_clr", {31'd0, err}, 32'd0);
    tick();
    chk("bp_idata_nop", idata, 32'd0);
    send_word(32'h20010005, 1);
    send_word(32'h00221020, 1);
    wait_core("bp_lat", fill_lat(2));
    fetch("bp_w0", 6'd0, 32'h20010005);
    fetch("bp_w1", 6'd1, 32'h00221020);

    // reload len=1
    do_start(7'd1);
    chk("rl_core_drop", {31'd0, core_nrst}, 32'd0);
    tick();
    chk("rl_idata_nop", idata, 32'd0);
    send_word(32'h3C01BEEF, 0);
    wait_core("rl_lat", fill_lat(1));
    fetch("rl_w0", 6'd0, 32'h3C01BEEF);
`ifdef IMEM_ZERO_FILL_EN
    fetch("rl_w1", 6'd1, 32'h00000000);
`else
    fetch("rl_w1", 6'd1, 32'h00221020);
`endif

    // preload word 5, then shorter load
    do_start(7'd6);
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + i, 0);
    send_word(32'hFFFFFFFF, 0);
    wait_core("pre_lat", fill_lat(6));
    fetch("pre_w5", 6'd5, 32'hFFFFFFFF);
    do_start(7'd3);
    send_word(32'h0000000A, 0);
    send_word(32'h0000000B, 0);
    send_word(32'h0000000C, 0);
`ifdef IMEM_ZERO_FILL_EN
    chk("fill_busy", {31'd0, busy}, 32'd1);
`else
    chk("fill_busy", {31'd0, busy}, 32'd0);
`endif
    wait_core("fill_lat", fill_lat(3));
    fetch("fill_w2", 6'd2, 32'h0000000C);
`ifdef IMEM_ZERO_FILL_EN
    fetch("fill_w5", 6'd5, 32'h00000000);
`else
    fetch("fill_w5", 6'd5, 32'hFFFFFFFF);
`endif

    // reset mid-load after 5 bytes
    do_start(7'd2);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    nrst = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_core", {31'd0, core_nrst}, 32'd0);
    chk("mid_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_mem0", dut.mem[0], 32'h11223344);
    tick();
    nrst = 1'b1;
    tick();
    do_start(7'd1);
    send_word(32'hCAFEF00D, 0);
    wait_core("mid_lat", fill_lat(1));
    fetch("mid_w0", 6'd0, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
